// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable data memory behind a request/response handshake.
// Handles byte/half/word/double accesses with byte-lane stores, sign/zero-extended
// loads, a configurable read latency and misaligned/out-of-range error flags.
// Only one request is outstanding at a time.
//
// Ports:
//   clk_in, rst_n_in              clock and synchronous active-low reset
//   req_valid_in / req_ready_out  request handshake
//   req_write_in                  1 = store, 0 = load
//   req_size_in                   0 byte, 1 half, 2 word, 3 double
//   req_unsigned_in               load zero-extends when 1
//   address_in, data_in           byte address and right-aligned store data
//   resp_valid_out / resp_ready_in response handshake
//   data_out                      extended load data (0 for stores/errors)
//   misaligned_out, out_of_range_out response error flags
module data_memory_lsu #(
  parameter int ADDR_WIDTH      = 64,
  parameter int WORD_BYTES_2POW = 3,
  parameter int WORD_BYTES      = 1 << WORD_BYTES_2POW,
  parameter int DATA_WIDTH      = WORD_BYTES * 8,
  parameter int DEPTH_2POW      = 12,
  parameter int READ_LATENCY    = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [1:0]            req_size_in,
  input  logic                  req_unsigned_in,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  misaligned_out,
  output logic                  out_of_range_out
);

  localparam int DEPTH   = 1 << DEPTH_2POW;
  localparam int TOP_LSB = WORD_BYTES_2POW + DEPTH_2POW;
  localparam int OW      = WORD_BYTES_2POW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_r;
  logic                   ready_r;
  logic                   resp_valid_r;
  logic                   mis_r;
  logic                   oor_r;
  logic [DATA_WIDTH-1:0]  data_r;
  logic [1:0]             cnt_r;
  logic [DEPTH_2POW-1:0]  ld_idx_r;
  logic [WORD_BYTES_2POW-1:0] ld_off_r;
  logic [1:0]             ld_size_r;
  logic                   ld_uns_r;
  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];

  logic [WORD_BYTES_2POW-1:0] off_s;
  logic [DEPTH_2POW-1:0]  idx_s;
  logic [OW-1:0]          amask_s;
  logic                   mis_s;
  logic                   oor_s;
  logic                   err_s;
  logic                   accept_s;
  logic                   store_s;
  logic [WORD_BYTES-1:0]  be_s;
  logic [DATA_WIDTH-1:0]  wdata_s;

  logic [DATA_WIDTH-1:0]  rd_shift_s;
  logic [DATA_WIDTH-1:0]  rd_mask_s;
  logic [DATA_WIDTH-1:0]  load_s;
  logic [6:0]             nbits_s;
  logic                   sign_s;

  assign req_ready_out    = ready_r;
  assign resp_valid_out   = resp_valid_r;
  assign data_out         = data_r;
  assign misaligned_out   = mis_r;
  assign out_of_range_out = oor_r;

  // Request decode: word index, lane offset, error checks and store lane enables.
  always_comb begin
    off_s    = address_in[WORD_BYTES_2POW-1:0];
    idx_s    = address_in[WORD_BYTES_2POW +: DEPTH_2POW];
    // Low-bit mask of the access size; any offset bit under it means misaligned.
    amask_s  = (OW'(1) << req_size_in) - OW'(1);
    mis_s    = (({1'b0, off_s} & amask_s) != '0) || (int'(req_size_in) > WORD_BYTES_2POW);
    oor_s    = |address_in[ADDR_WIDTH-1:TOP_LSB];
    err_s    = mis_s | oor_s;
    // Reset gating keeps a request presented during reset from writing RAM.
    accept_s = req_valid_in & ready_r & rst_n_in;
    store_s  = accept_s & req_write_in & ~err_s;
    be_s     = '0;
    for (int l = 0; l < WORD_BYTES; l++) begin
      be_s[l] = (l >= int'(off_s)) && (l < int'(off_s) + (1 << req_size_in));
    end
    wdata_s  = data_in << {off_s, 3'b000};
  end

  // Load extraction: right-align the addressed lanes and extend to the bus width.
  always_comb begin
    rd_shift_s = mem_r[ld_idx_r] >> {ld_off_r, 3'b000};
    nbits_s    = 7'd8 << ld_size_r;
    // Shifting by the full width yields zero, so a full-width access gets an all-ones mask.
    rd_mask_s  = ~({DATA_WIDTH{1'b1}} << nbits_s);
    // Top bit of the mask selects the sign bit without a variable bit index.
    sign_s     = |(rd_shift_s & rd_mask_s & ~(rd_mask_s >> 1));
    if (sign_s && !ld_uns_r) begin
      load_s = rd_shift_s | ~rd_mask_s;
    end else begin
      load_s = rd_shift_s & rd_mask_s;
    end
  end

  // RAM byte-lane write at the accept edge of a valid store; contents are not reset.
  always_ff @(posedge clk_in) begin
    if (store_s) begin
      for (int l = 0; l < WORD_BYTES; l++) begin
        if (be_s[l]) begin
          mem_r[idx_s][8*l +: 8] <= wdata_s[8*l +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake, data and flag outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      mis_r        <= 1'b0;
      oor_r        <= 1'b0;
      data_r       <= '0;
      cnt_r        <= 2'd0;
      ld_idx_r     <= '0;
      ld_off_r     <= '0;
      ld_size_r    <= 2'd0;
      ld_uns_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ready_r <= 1'b0;
            if (err_s || req_write_in) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              mis_r        <= mis_s;
              oor_r        <= oor_s;
              data_r       <= '0;
            end else begin
              // The read happens when the counter has drained, READ_LATENCY edges later.
              state_r   <= ST_WAIT;
              cnt_r     <= 2'(READ_LATENCY - 1);
              ld_idx_r  <= idx_s;
              ld_off_r  <= off_s;
              ld_size_r <= req_size_in;
              ld_uns_r  <= req_unsigned_in;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 2'd0) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            data_r       <= load_s;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready_in) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            mis_r        <= 1'b0;
            oor_r        <= 1'b0;
            data_r       <= '0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          ready_r      <= 1'b1;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: a 64-bit instance with READ_LATENCY=3
// and a 32-bit-word instance with READ_LATENCY=1, checked against constants and a
// byte-array reference model.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] address;
  logic [63:0] wdata;
  logic        resp_ready;

  logic        valid64, ready64, rvalid64, mis64, oor64;
  logic [63:0] dout64;
  logic        valid32, ready32, rvalid32, mis32, oor32;
  logic [31:0] dout32;

  int total = 0;
  int bad   = 0;

  byte unsigned ref_mem [256];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        un;
    logic [63:0] addr;
    logic [63:0] dat;
    logic [63:0] exp_d;
    logic        exp_mis;
    logic        exp_oor;
    int          exp_lat;
  } op_t;

  data_memory_lsu #(.READ_LATENCY(3)) u_dut64 (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(valid64), .req_ready_out(ready64),
    .req_write_in(req_write), .req_size_in(req_size), .req_unsigned_in(req_unsigned),
    .address_in(address), .data_in(wdata),
    .resp_valid_out(rvalid64), .resp_ready_in(resp_ready),
    .data_out(dout64), .misaligned_out(mis64), .out_of_range_out(oor64)
  );

  data_memory_lsu #(.WORD_BYTES_2POW(2), .DEPTH_2POW(4), .READ_LATENCY(1)) u_dut32 (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(valid32), .req_ready_out(ready32),
    .req_write_in(req_write), .req_size_in(req_size), .req_unsigned_in(req_unsigned),
    .address_in(address), .data_in(wdata[31:0]),
    .resp_valid_out(rvalid32), .resp_ready_in(resp_ready),
    .data_out(dout32), .misaligned_out(mis32), .out_of_range_out(oor32)
  );

  // One full transaction; lat = edges from the accept edge until resp_valid is seen.
  task automatic xact(input logic sel32, input logic w, input logic [1:0] sz, input logic un,
                      input logic [63:0] addr, input logic [63:0] dat,
                      output logic [63:0] d, output logic mis, output logic oor,
                      output int lat, output logic ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = un; address = addr; wdata = dat;
    resp_ready = 1'b1;
    if (sel32) valid32 = 1'b1; else valid64 = 1'b1;
    n = 0;
    while (!(sel32 ? ready32 : ready64) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) ok = 1'b0;
    @(posedge clk); #1;
    valid32 = 1'b0; valid64 = 1'b0;
    lat = 0;
    while (!(sel32 ? rvalid32 : rvalid64) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) ok = 1'b0;
    d   = sel32 ? {32'd0, dout32} : dout64;
    mis = sel32 ? mis32 : mis64;
    oor = sel32 ? oor32 : oor64;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid64 = 1'b0; valid32 = 1'b0; resp_ready = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; address = 64'd0; wdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ready64 !== 1'b1) begin bad++; $display("FAIL reset_ready64 got=%b exp=1", ready64); end
    total++; if (rvalid64 !== 1'b0) begin bad++; $display("FAIL reset_rvalid64 got=%b exp=0", rvalid64); end
    total++; if (dout64 !== 64'd0) begin bad++; $display("FAIL reset_data64 got=%h exp=0", dout64); end
    total++; if ({mis64, oor64} !== 2'b00) begin bad++; $display("FAIL reset_flags64 got=%b exp=00", {mis64, oor64}); end
    total++; if ({ready32, rvalid32} !== 2'b10) begin bad++; $display("FAIL reset_hs32 got=%b exp=10", {ready32, rvalid32}); end
  endtask

  task automatic test_directed();
    op_t tbl [16];
    logic [63:0] d; logic mis, oor, ok; int lat;
    tbl[0]  = '{1'b1, 2'd3, 1'b0, 64'h40,   64'h1122334455667788, 64'd0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 64'h47,   64'd0, 64'h11, 1'b0, 1'b0, 3};
    tbl[2]  = '{1'b0, 2'd1, 1'b0, 64'h46,   64'd0, 64'h1122, 1'b0, 1'b0, 3};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 64'h44,   64'd0, 64'h11223344, 1'b0, 1'b0, 3};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 64'h41,   64'hAAAAAAAAAAAAAA80, 64'd0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 64'h41,   64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 64'h41,   64'd0, 64'h80, 1'b0, 1'b0, 3};
    tbl[7]  = '{1'b0, 2'd3, 1'b0, 64'h40,   64'd0, 64'h1122334455668088, 1'b0, 1'b0, 3};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 64'h43,   64'd0, 64'd0, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 64'h8000, 64'd0, 64'd0, 1'b0, 1'b1, 0};
    tbl[10] = '{1'b0, 2'd1, 1'b0, 64'h8001, 64'd0, 64'd0, 1'b1, 1'b1, 0};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 64'h43,   64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 1'b0, 0};
    tbl[12] = '{1'b0, 2'd3, 1'b1, 64'h40,   64'd0, 64'h1122334455668088, 1'b0, 1'b0, 3};
    tbl[13] = '{1'b0, 2'd1, 1'b0, 64'h40,   64'd0, 64'hFFFFFFFFFFFF8088, 1'b0, 1'b0, 3};
    tbl[14] = '{1'b0, 2'd1, 1'b1, 64'h40,   64'd0, 64'h8088, 1'b0, 1'b0, 3};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 64'h40,   64'd0, 64'h55668088, 1'b0, 1'b0, 3};
    for (int i = 0; i < 16; i++) begin
      xact(1'b0, tbl[i].w, tbl[i].sz, tbl[i].un, tbl[i].addr, tbl[i].dat, d, mis, oor, lat, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL dir_timeout op=%0d", i); end
      total++; if (d !== tbl[i].exp_d) begin bad++; $display("FAIL dir_data op=%0d got=%h exp=%h", i, d, tbl[i].exp_d); end
      total++; if ({mis, oor} !== {tbl[i].exp_mis, tbl[i].exp_oor}) begin bad++; $display("FAIL dir_flags op=%0d got=%b exp=%b", i, {mis, oor}, {tbl[i].exp_mis, tbl[i].exp_oor}); end
      total++; if (lat != tbl[i].exp_lat) begin bad++; $display("FAIL dir_latency op=%0d got=%0d exp=%0d", i, lat, tbl[i].exp_lat); end
    end
  endtask

  task automatic test_narrow_word();
    op_t tbl [6];
    logic [63:0] d; logic mis, oor, ok; int lat;
    tbl[0] = '{1'b1, 2'd2, 1'b0, 64'h8,  64'h55555555DEADBEEF, 64'd0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 2'd3, 1'b0, 64'h4,  64'd0, 64'd0, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b0, 2'd3, 1'b0, 64'h8,  64'd0, 64'd0, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b0, 2'd1, 1'b0, 64'hA,  64'd0, 64'h00000000FFFFDEAD, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 64'h8,  64'd0, 64'hEF, 1'b0, 1'b0, 1};
    tbl[5] = '{1'b0, 2'd2, 1'b0, 64'h40, 64'd0, 64'd0, 1'b0, 1'b1, 0};
    for (int i = 0; i < 6; i++) begin
      xact(1'b1, tbl[i].w, tbl[i].sz, tbl[i].un, tbl[i].addr, tbl[i].dat, d, mis, oor, lat, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL n32_timeout op=%0d", i); end
      total++; if (d !== tbl[i].exp_d) begin bad++; $display("FAIL n32_data op=%0d got=%h exp=%h", i, d, tbl[i].exp_d); end
      total++; if ({mis, oor} !== {tbl[i].exp_mis, tbl[i].exp_oor}) begin bad++; $display("FAIL n32_flags op=%0d got=%b exp=%b", i, {mis, oor}, {tbl[i].exp_mis, tbl[i].exp_oor}); end
      total++; if (lat != tbl[i].exp_lat) begin bad++; $display("FAIL n32_latency op=%0d got=%0d exp=%0d", i, lat, tbl[i].exp_lat); end
    end
  endtask

  task automatic test_latency_hold();
    logic [2:0] seen;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b1; address = 64'h44; wdata = 64'd0;
    resp_ready = 1'b0; valid64 = 1'b1;
    total++; if (ready64 !== 1'b1) begin bad++; $display("FAIL hold_idle_ready got=%b exp=1", ready64); end
    @(posedge clk); #1;
    valid64 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      seen[k] = rvalid64;
    end
    total++; if (seen !== 3'b100) begin bad++; $display("FAIL hold_latency rvalid_after_1_2_3=%b exp=100", {seen[0], seen[1], seen[2]}); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if ({rvalid64, ready64, mis64, oor64, dout64} !== {4'b1000, 64'h11223344}) begin
        bad++;
        $display("FAIL hold_stable cycle=%0d got v=%b r=%b f=%b d=%h exp v=1 r=0 f=00 d=11223344",
                 k, rvalid64, ready64, {mis64, oor64}, dout64);
      end
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if ({rvalid64, ready64} !== 2'b01) begin bad++; $display("FAIL hold_release got v=%b r=%b exp v=0 r=1", rvalid64, ready64); end
  endtask

  task automatic test_reset_wait();
    logic [63:0] d; logic mis, oor, ok; int lat; int hits;
    xact(1'b0, 1'b1, 2'd3, 1'b0, 64'h80, 64'h0123456789ABCDEF, d, mis, oor, lat, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstw_store_timeout"); end
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd3; address = 64'h80; valid64 = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    valid64 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rvalid64 === 1'b1) hits++;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL rstw_no_resp got=%0d exp=0", hits); end
    total++; if (ready64 !== 1'b1) begin bad++; $display("FAIL rstw_ready got=%b exp=1", ready64); end
    xact(1'b0, 1'b0, 2'd3, 1'b0, 64'h80, 64'd0, d, mis, oor, lat, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstw_load_timeout"); end
    total++; if (d !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL rstw_data got=%h exp=0123456789abcdef", d); end
  endtask

  task automatic test_random();
    logic [63:0] d, v, dat, addr; logic mis, oor, ok, w, un, emis, eoor; logic [1:0] sz;
    int lat, n, elat;
    for (int a = 0; a < 256; a += 8) begin
      dat = {$urandom, $urandom};
      xact(1'b0, 1'b1, 2'd3, 1'b0, 64'(a), dat, d, mis, oor, lat, ok);
      for (int i = 0; i < 8; i++) ref_mem[a + i] = dat[8*i +: 8];
    end
    for (int t = 0; t < 80; t++) begin
      w    = ($urandom_range(0, 2) == 0);
      sz   = 2'($urandom_range(0, 3));
      un   = 1'($urandom_range(0, 1));
      dat  = {$urandom, $urandom};
      addr = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) addr = addr | (64'd1 << $urandom_range(15, 63));
      n    = 1 << sz;
      emis = (addr % 64'(n)) != 64'd0;
      eoor = (addr >> 15) != 64'd0;
      v    = 64'd0;
      elat = 0;
      if (!emis && !eoor) begin
        if (w) begin
          for (int i = 0; i < n; i++) ref_mem[int'(addr[7:0]) + i] = dat[8*i +: 8];
        end else begin
          elat = 3;
          for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr[7:0]) + i]) << (8 * i));
          if (!un && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
      end
      xact(1'b0, w, sz, un, addr, dat, d, mis, oor, lat, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rnd_timeout op=%0d", t); end
      total++; if (d !== v) begin bad++; $display("FAIL rnd_data op=%0d addr=%h sz=%0d w=%b got=%h exp=%h", t, addr, sz, w, d, v); end
      total++; if ({mis, oor} !== {emis, eoor}) begin bad++; $display("FAIL rnd_flags op=%0d addr=%h sz=%0d got=%b exp=%b", t, addr, sz, {mis, oor}, {emis, eoor}); end
      total++; if (lat != elat) begin bad++; $display("FAIL rnd_latency op=%0d got=%0d exp=%0d", t, lat, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_narrow_word();
    test_latency_hold();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
